// File: rtl/ahbl_slv_mem_pkg.sv
// AHB-Lite subordinate memory: shared bus encodings,
// FSM state type and byte-lane strobe helper.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  function automatic logic [3:0] lane_strb(
    input logic [2:0] size,
    input logic [1:0] a
  );
    logic [3:0] s;
    s = '0;
    unique case (1'b1)
      size == HSIZE_BYTE: s = 4'b0001 << a;
      size == HSIZE_HALF: s = a[1] ? 4'b1100 : 4'b0011;
      size == HSIZE_WORD: s = 4'b1111;
      default:            s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ahbl_slv_mem_if.sv
// AHB-Lite bus bundle between a manager and this
// subordinate; hready is the bus-level ready.
interface ahbl_slv_mem_if;

  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  modport master (
    output hsel, haddr, htrans, hsize,
    output hburst, hprot, hwrite, hwdata,
    output hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hsize,
    input  hburst, hprot, hwrite, hwdata,
    input  hready,
    output hrdata, hreadyout, hresp
  );

endinterface

// File: rtl/ahbl_slv_mem_ram.sv
// Word-organised RAM with byte write enables and a
// registered, write-first read port.
module ahbl_slv_mem_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];
  logic        same;

  assign same = (waddr == raddr);

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    // lanes written this edge are forwarded to the read
    if (re) begin
      for (int i = 0; i < 4; i++) begin
        rdata[8*i +: 8] <= (we[i] && same)
                         ? wdata[8*i +: 8]
                         : mem[raddr][8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/ahbl_slv_mem.sv
// AHB-Lite subordinate scratch RAM with optional wait
// states and two-cycle ERROR for bad accesses.
import ahbl_pkg::*;

module ahbl_slv_mem #(
  parameter int          AW          = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 0
) (
  input logic           hclk,
  input logic           hreset,
  ahbl_slv_mem_if.slave bus
);

  localparam logic [31:0] SPAN_MASK =
    (32'd4 << AW) - 32'd1;
  localparam logic [3:0] WS_LOAD =
    4'(WAIT_STATES - 1);

  state_e        state, state_nx;
  logic [3:0]    wcnt, wcnt_nx;
  logic          dp_ok, dp_ok_nx;
  logic          dp_wr, dp_wr_nx;
  logic          dp_rerr, dp_rerr_nx;
  logic [AW+1:0] dp_addr, dp_addr_nx;
  logic [2:0]    dp_size, dp_size_nx;

  logic          accept, rdy;
  logic          out_rng, bad_size, misal, acc_err;
  logic          commit, rd_done, err_rd_done;
  logic          ram_re;
  logic [3:0]    ram_we;
  logic [31:0]   ram_rdata, rd_hold;
  logic          unused_ok;

  assign unused_ok = ^{bus.hburst, bus.hprot};

  assign accept = bus.hsel & bus.hready
                & bus.htrans[1];
  assign rdy    = (state == ST_IDLE)
                | (state == ST_ERR2);

  assign out_rng  = (bus.haddr & ~SPAN_MASK)
                  != BASE_ADDR;
  assign bad_size = bus.hsize > HSIZE_WORD;
  assign misal    =
      ((bus.hsize == HSIZE_HALF) & bus.haddr[0])
    | ((bus.hsize == HSIZE_WORD) & |bus.haddr[1:0]);
  assign acc_err  = out_rng | bad_size | misal;

  assign commit      = (state == ST_IDLE) & dp_ok;
  assign rd_done     = commit & ~dp_wr;
  assign err_rd_done = (state == ST_ERR2) & dp_rerr;

  // a beat still pending when reset lands never commits
  assign ram_we = (commit & dp_wr & ~hreset)
                ? lane_strb(dp_size, dp_addr[1:0])
                : 4'b0000;
  assign ram_re = accept & rdy & ~acc_err
                & ~bus.hwrite & ~hreset;

  always_comb begin
    state_nx   = state;
    wcnt_nx    = wcnt;
    dp_ok_nx   = dp_ok;
    dp_wr_nx   = dp_wr;
    dp_rerr_nx = dp_rerr;
    dp_addr_nx = dp_addr;
    dp_size_nx = dp_size;
    unique case (state)
      ST_IDLE, ST_ERR2: begin
        state_nx   = ST_IDLE;
        dp_ok_nx   = 1'b0;
        dp_rerr_nx = 1'b0;
        if (accept) begin
          dp_addr_nx = bus.haddr[AW+1:0];
          dp_size_nx = bus.hsize;
          dp_wr_nx   = bus.hwrite;
          dp_ok_nx   = ~acc_err;
          dp_rerr_nx = acc_err & ~bus.hwrite;
          if (acc_err) begin
            state_nx = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nx = ST_WAIT;
            wcnt_nx  = WS_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt == 4'd0) state_nx = ST_IDLE;
        else              wcnt_nx  = wcnt - 4'd1;
      end
      ST_ERR1: state_nx = ST_ERR2;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= ST_IDLE;
      wcnt    <= '0;
      dp_ok   <= 1'b0;
      dp_wr   <= 1'b0;
      dp_rerr <= 1'b0;
      dp_addr <= '0;
      dp_size <= '0;
    end else begin
      state   <= state_nx;
      wcnt    <= wcnt_nx;
      dp_ok   <= dp_ok_nx;
      dp_wr   <= dp_wr_nx;
      dp_rerr <= dp_rerr_nx;
      dp_addr <= dp_addr_nx;
      dp_size <= dp_size_nx;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset)           rd_hold <= '0;
    else if (rd_done)     rd_hold <= ram_rdata;
    else if (err_rd_done) rd_hold <= '0;
  end

  ahbl_slv_mem_ram #(.AW(AW)) u_ram (
    .clk   (hclk),
    .we    (ram_we),
    .waddr (dp_addr[AW+1:2]),
    .wdata (bus.hwdata),
    .re    (ram_re),
    .raddr (bus.haddr[AW+1:2]),
    .rdata (ram_rdata)
  );

  // RAM output register drives the completing cycle only
  assign bus.hrdata    = rd_done     ? ram_rdata :
                         err_rd_done ? 32'h0     :
                                       rd_hold;
  assign bus.hreadyout = rdy;
  assign bus.hresp     = (state == ST_ERR1)
                       | (state == ST_ERR2);

endmodule

// File: tb/tb_ahbl_slv_mem.sv
// Directed bench for ahbl_slv_mem: zero-wait instance
// at 0x4000_0000 and a 3-wait-state instance at 0.
module tb_ahbl_slv_mem;
  import ahbl_pkg::*;

  localparam logic [31:0] B0 = 32'h4000_0000;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel0, hsel3, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;

  int nvec = 0;
  int nerr = 0;

  always #5 hclk = ~hclk;

  ahbl_slv_mem_if b0 ();
  ahbl_slv_mem_if b3 ();

  assign b0.hsel   = hsel0;
  assign b0.haddr  = haddr;
  assign b0.htrans = htrans;
  assign b0.hsize  = hsize;
  assign b0.hburst = 3'b001;
  assign b0.hprot  = 4'b0011;
  assign b0.hwrite = hwrite;
  assign b0.hwdata = hwdata;
  assign b0.hready = b0.hreadyout;

  assign b3.hsel   = hsel3;
  assign b3.haddr  = haddr;
  assign b3.htrans = htrans;
  assign b3.hsize  = hsize;
  assign b3.hburst = 3'b000;
  assign b3.hprot  = 4'b0011;
  assign b3.hwrite = hwrite;
  assign b3.hwdata = hwdata;
  assign b3.hready = b3.hreadyout;

  ahbl_slv_mem #(
    .AW(10), .BASE_ADDR(B0), .WAIT_STATES(0)
  ) u0 (.hclk(hclk), .hreset(hreset), .bus(b0));

  ahbl_slv_mem #(
    .AW(10), .BASE_ADDR(32'h0), .WAIT_STATES(3)
  ) u3 (.hclk(hclk), .hreset(hreset), .bus(b3));

  function automatic logic rdy(input bit s3);
    return s3 ? b3.hreadyout : b0.hreadyout;
  endfunction

  function automatic logic rsp(input bit s3);
    return s3 ? b3.hresp : b0.hresp;
  endfunction

  function automatic logic [31:0] rdat(input bit s3);
    return s3 ? b3.hrdata : b0.hrdata;
  endfunction

  task automatic idle_bus();
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    hsize  = HSIZE_WORD;
  endtask

  // single beat; starts and ends at posedge+1
  task automatic xfer(
    input  bit          s3,
    input  bit          wr,
    input  logic [31:0] a,
    input  logic [2:0]  sz,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        rf,
    output logic        rl,
    output int          waits
  );
    hsel0  = !s3;
    hsel3  = s3;
    haddr  = a;
    htrans = HTRANS_NONSEQ;
    hwrite = wr;
    hsize  = sz;
    @(posedge hclk); #1;
    idle_bus();
    hwdata = wd;
    rf     = rsp(s3);
    waits  = 0;
    while (!rdy(s3) && waits < 50) begin
      @(posedge hclk); #1;
      waits++;
    end
    rd = rdat(s3);
    rl = rsp(s3);
    @(posedge hclk); #1;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    idle_bus();
    haddr  = '0;
    hwdata = '0;
    repeat (2) @(posedge hclk);
    #1;
    for (int s = 0; s < 2; s++) begin
      nvec++;
      if ({rdy(s[0]), rsp(s[0]), rdat(s[0])}
          !== {1'b1, 1'b0, 32'h0}) begin
        nerr++;
        $display("FAIL reset_%0d: rdy/rsp/rdata %b/%b/%h want 1/0/0",
                 s, rdy(s[0]), rsp(s[0]), rdat(s[0]));
      end
    end
    hreset = 1'b0;
    @(posedge hclk); #1;
  endtask

  task automatic test_word_rw();
    logic [31:0] rd;
    logic        rf, rl;
    int          w;
    xfer(0, 1, B0 + 32'h10, HSIZE_WORD,
         32'hDEAD_BEEF, rd, rf, rl, w);
    nvec++;
    if ({w, rl} !== {32'd0, 1'b0}) begin
      nerr++;
      $display("FAIL word_wr: waits/resp %0d/%b want 0/0", w, rl);
    end
    xfer(0, 0, B0 + 32'h10, HSIZE_WORD,
         32'h0, rd, rf, rl, w);
    nvec++;
    if ({w, rl, rd} !== {32'd0, 1'b0, 32'hDEAD_BEEF}) begin
      nerr++;
      $display("FAIL word_rd: waits/resp/data %0d/%b/%h want 0/0/deadbeef",
               w, rl, rd);
    end
    nvec++;
    if (b0.hrdata !== 32'hDEAD_BEEF) begin
      nerr++;
      $display("FAIL rdata_hold: got %h want deadbeef", b0.hrdata);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd;
    logic        rf, rl;
    int          w;
    xfer(0, 1, B0 + 32'h10, HSIZE_WORD,
         32'h1122_3344, rd, rf, rl, w);
    xfer(0, 1, B0 + 32'h13, HSIZE_BYTE,
         32'hAA5A_5A5A, rd, rf, rl, w);
    xfer(0, 0, B0 + 32'h10, HSIZE_WORD,
         32'h0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'hAA22_3344) begin
      nerr++;
      $display("FAIL byte3: got %h want aa223344", rd);
    end
    xfer(0, 1, B0 + 32'h12, HSIZE_HALF,
         32'h5566_A5A5, rd, rf, rl, w);
    xfer(0, 0, B0 + 32'h10, HSIZE_WORD,
         32'h0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'h5566_3344) begin
      nerr++;
      $display("FAIL half_hi: got %h want 55663344", rd);
    end
    xfer(0, 1, B0 + 32'h10, HSIZE_BYTE,
         32'h1234_5677, rd, rf, rl, w);
    xfer(0, 0, B0 + 32'h10, HSIZE_WORD,
         32'h0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'h5566_3377) begin
      nerr++;
      $display("FAIL byte0: got %h want 55663377", rd);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    logic        rf, rl;
    int          w;
    xfer(1, 1, 32'h40, HSIZE_WORD,
         32'h0BAD_F00D, rd, rf, rl, w);
    nvec++;
    if ({w, rl} !== {32'd3, 1'b0}) begin
      nerr++;
      $display("FAIL ws_wr: waits/resp %0d/%b want 3/0", w, rl);
    end
    xfer(1, 0, 32'h40, HSIZE_WORD,
         32'h0, rd, rf, rl, w);
    nvec++;
    if ({w, rf, rl, rd}
        !== {32'd3, 1'b0, 1'b0, 32'h0BAD_F00D}) begin
      nerr++;
      $display("FAIL ws_rd: waits/resp/data %0d/%b/%h want 3/0/0badf00d",
               w, rl, rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        rf, rl;
    int          w;
    xfer(0, 1, B0, HSIZE_WORD,
         32'h0102_0304, rd, rf, rl, w);
    xfer(0, 1, B0 + 32'h1000, HSIZE_WORD,
         32'hCAFE_F00D, rd, rf, rl, w);
    nvec++;
    if ({w, rf, rl} !== {32'd1, 1'b1, 1'b1}) begin
      nerr++;
      $display("FAIL err_range: waits/r1/r2 %0d/%b/%b want 1/1/1",
               w, rf, rl);
    end
    xfer(0, 0, B0 + 32'h2, HSIZE_WORD,
         32'h0, rd, rf, rl, w);
    nvec++;
    if ({w, rf, rl, rd}
        !== {32'd1, 1'b1, 1'b1, 32'h0}) begin
      nerr++;
      $display("FAIL err_misal_rd: waits/r1/r2/data %0d/%b/%b/%h want 1/1/1/0",
               w, rf, rl, rd);
    end
    xfer(0, 1, B0 + 32'h1, HSIZE_HALF,
         32'hFFFF_FFFF, rd, rf, rl, w);
    nvec++;
    if ({w, rf, rl} !== {32'd1, 1'b1, 1'b1}) begin
      nerr++;
      $display("FAIL err_half: waits/r1/r2 %0d/%b/%b want 1/1/1",
               w, rf, rl);
    end
    xfer(0, 1, B0, 3'd3,
         32'hFFFF_FFFF, rd, rf, rl, w);
    nvec++;
    if ({w, rf, rl} !== {32'd1, 1'b1, 1'b1}) begin
      nerr++;
      $display("FAIL err_size: waits/r1/r2 %0d/%b/%b want 1/1/1",
               w, rf, rl);
    end
    xfer(0, 0, B0, HSIZE_WORD,
         32'h0, rd, rf, rl, w);
    nvec++;
    if ({rl, rd} !== {1'b0, 32'h0102_0304}) begin
      nerr++;
      $display("FAIL err_nowrite: resp/data %b/%h want 0/01020304",
               rl, rd);
    end
  endtask

  task automatic test_idle_busy();
    hsel0  = 1'b1;
    htrans = HTRANS_IDLE;
    haddr  = B0 + 32'h3;
    @(posedge hclk); #1;
    htrans = HTRANS_BUSY;
    @(posedge hclk); #1;
    idle_bus();
    nvec++;
    if ({rdy(0), rsp(0), rdat(0)}
        !== {1'b1, 1'b0, 32'h0102_0304}) begin
      nerr++;
      $display("FAIL idle_busy: rdy/rsp/data %b/%b/%h want 1/0/01020304",
               rdy(0), rsp(0), rdat(0));
    end
    @(posedge hclk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [4];
    logic [31:0] rd;
    logic        rf, rl;
    int          w;
    d[0] = 32'hA0A0_0001;
    d[1] = 32'hB1B1_0002;
    d[2] = 32'hC2C2_0003;
    d[3] = 32'hD3D3_0004;
    hsel0  = 1'b1;
    haddr  = B0 + 32'h20;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    for (int i = 1; i <= 4; i++) begin
      @(posedge hclk); #1;
      nvec++;
      if ({rdy(0), rsp(0)} !== 2'b10) begin
        nerr++;
        $display("FAIL burst_beat%0d: rdy/resp %b/%b want 1/0",
                 i - 1, rdy(0), rsp(0));
      end
      hwdata = d[i-1];
      if (i < 4) begin
        haddr  = B0 + 32'h20 + 32'(4 * i);
        htrans = HTRANS_SEQ;
      end else begin
        haddr  = B0 + 32'h20;
        htrans = HTRANS_NONSEQ;
        hwrite = 1'b0;
      end
    end
    @(posedge hclk); #1;
    idle_bus();
    nvec++;
    if ({rdy(0), rsp(0), rdat(0)}
        !== {1'b1, 1'b0, d[0]}) begin
      nerr++;
      $display("FAIL burst_rd: rdy/resp/data %b/%b/%h want 1/0/%h",
               rdy(0), rsp(0), rdat(0), d[0]);
    end
    @(posedge hclk); #1;
    xfer(0, 0, B0 + 32'h2C, HSIZE_WORD,
         32'h0, rd, rf, rl, w);
    nvec++;
    if (rd !== d[3]) begin
      nerr++;
      $display("FAIL burst_last: got %h want %h", rd, d[3]);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] wd [2];
    logic [31:0] ex [2];
    logic [2:0]  sz [2];
    logic [31:0] ad [2];
    wd[0] = 32'h1357_9BDF; ex[0] = 32'h1357_9BDF;
    wd[1] = 32'h0000_EE00; ex[1] = 32'h1357_EEDF;
    sz[0] = HSIZE_WORD;    sz[1] = HSIZE_BYTE;
    ad[0] = B0 + 32'h30;   ad[1] = B0 + 32'h31;
    for (int k = 0; k < 2; k++) begin
      hsel0  = 1'b1;
      haddr  = ad[k];
      htrans = HTRANS_NONSEQ;
      hwrite = 1'b1;
      hsize  = sz[k];
      @(posedge hclk); #1;
      hwdata = wd[k];
      haddr  = B0 + 32'h30;
      hwrite = 1'b0;
      hsize  = HSIZE_WORD;
      @(posedge hclk); #1;
      idle_bus();
      nvec++;
      if ({rdy(0), rdat(0)} !== {1'b1, ex[k]}) begin
        nerr++;
        $display("FAIL bypass_%0d: rdy/data %b/%h want 1/%h",
                 k, rdy(0), rdat(0), ex[k]);
      end
      @(posedge hclk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    logic        rf, rl;
    int          w;
    xfer(1, 1, 32'h80, HSIZE_WORD,
         32'h1234_5678, rd, rf, rl, w);
    hsel3  = 1'b1;
    haddr  = 32'h80;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    @(posedge hclk); #1;
    idle_bus();
    hwdata = 32'hFFFF_FFFF;
    nvec++;
    if (rdy(1) !== 1'b0) begin
      nerr++;
      $display("FAIL rst_wait_in: rdy %b want 0", rdy(1));
    end
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    nvec++;
    if ({rdy(1), rsp(1), rdat(1)}
        !== {1'b1, 1'b0, 32'h0}) begin
      nerr++;
      $display("FAIL rst_wait_out: rdy/rsp/data %b/%b/%h want 1/0/0",
               rdy(1), rsp(1), rdat(1));
    end
    @(posedge hclk); #1;
    xfer(1, 0, 32'h80, HSIZE_WORD,
         32'h0, rd, rf, rl, w);
    nvec++;
    if ({w, rd} !== {32'd3, 32'h1234_5678}) begin
      nerr++;
      $display("FAIL rst_wait_mem: waits/data %0d/%h want 3/12345678",
               w, rd);
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_lanes();
    test_wait_states();
    test_errors();
    test_idle_busy();
    test_back_to_back();
    test_bypass();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
